// File: rtl/ling_adder_pipe_pkg.sv
// ============================================================================
// Module  : ling_pkg
// Brief   : Shared constants and configuration checks for the Ling adder pipe.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ling_pkg;

    localparam int BLK_W = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int blk_count(input int width);
        return width / BLK_W;
    endfunction

    // Legal when WIDTH is a positive multiple of the block width and the
    // blocks divide evenly across the stages.
    function automatic bit cfg_ok(input int width, input int stages);
        if (width < BLK_W)           return 1'b0;
        if ((width % BLK_W) != 0)    return 1'b0;
        if (stages < 1)              return 1'b0;
        if (stages > blk_count(width)) return 1'b0;
        return (blk_count(width) % stages) == 0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ling_adder_pipe_if.sv
// ============================================================================
// Module  : ling_adder_pipe_if
// Brief   : Operand/result handshake bundle for the pipelined Ling adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ling_adder_pipe_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

`default_nettype wire

// File: rtl/ling_adder_pipe_block4.sv
// ============================================================================
// Module  : ling_block4
// Brief   : Combinational 4-bit Ling carry slice (pseudo-carry h, real c=t&h).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ling_block4
    import ling_pkg::*;
(
    input  wire logic [BLK_W-1:0] p,
    input  wire logic [BLK_W-1:0] g,
    input  wire logic             cin,
    output logic      [BLK_W-1:0] sum,
    output logic                  cout
);

    logic [BLK_W-1:0] w_t;
    logic [BLK_W-1:0] w_h;
    logic [BLK_W-1:0] w_c;

    assign w_t = p | g;

    // Pseudo-carries in flattened form: each h term drops one transmit
    // factor compared with the classic carry-lookahead product.
    assign w_h[0] = g[0] | cin;
    assign w_h[1] = g[1] | (w_t[0] & g[0]) | (w_t[0] & cin);
    assign w_h[2] = g[2] | (w_t[1] & g[1]) | (w_t[1] & w_t[0] & g[0])
                  | (w_t[1] & w_t[0] & cin);
    assign w_h[3] = g[3] | (w_t[2] & g[2]) | (w_t[2] & w_t[1] & g[1])
                  | (w_t[2] & w_t[1] & w_t[0] & g[0])
                  | (w_t[2] & w_t[1] & w_t[0] & cin);

    assign w_c[0] = cin;
    assign w_c[1] = w_t[0] & w_h[0];
    assign w_c[2] = w_t[1] & w_h[1];
    assign w_c[3] = w_t[2] & w_h[2];

    assign sum  = p ^ w_c;
    assign cout = w_t[3] & w_h[3];

endmodule

`default_nettype wire

// File: rtl/ling_adder_pipe.sv
// ============================================================================
// Module  : ling_adder_pipe
// Brief   : WIDTH-bit pipelined Ling adder/subtractor, carry split over STAGES.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ling_adder_pipe
    import ling_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ling_adder_pipe_if.slave bus
);

    localparam int NB  = blk_count(WIDTH);
    localparam int BPS = NB / STAGES;
    localparam int SW  = BPS * BLK_W;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("ling_adder_pipe: illegal WIDTH/STAGES combination");
    end

    logic             w_advance;
    logic             w_sub;
    logic [WIDTH-1:0] w_bx;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    assign w_sub     = (op_e'(bus.sub) == OP_SUB);
    assign w_bx      = w_sub ? ~bus.b : bus.b;
    assign w_advance = !(r_out_valid && !bus.out_ready);

    assign bus.in_ready  = w_advance;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;

    // Stage s resolves bits [LO +: SW]; only the still-unsummed upper p/g
    // slices and the finished lower sum bits travel to the next stage.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = s * SW;
        localparam int HI = LO + SW;

        logic [WIDTH-LO-1:0] w_p;
        logic [WIDTH-LO-1:0] w_g;
        logic [BPS:0]        w_c;
        logic [HI-1:0]       w_s;
        logic                w_vin;

        if (s == 0) begin : g_head
            assign w_p    = bus.a ^ w_bx;
            assign w_g    = bus.a & w_bx;
            assign w_c[0] = w_sub | bus.cin;
            assign w_vin  = bus.in_valid;
        end else begin : g_body
            assign w_p         = g_stage[s-1].g_pipe.r_p;
            assign w_g         = g_stage[s-1].g_pipe.r_g;
            assign w_c[0]      = g_stage[s-1].g_pipe.r_c;
            assign w_s[LO-1:0] = g_stage[s-1].g_pipe.r_sum;
            assign w_vin       = g_stage[s-1].g_pipe.r_v;
        end

        for (genvar j = 0; j < BPS; j++) begin : g_blk
            ling_block4 u_blk (
                .p    (w_p[j*BLK_W +: BLK_W]),
                .g    (w_g[j*BLK_W +: BLK_W]),
                .cin  (w_c[j]),
                .sum  (w_s[LO + j*BLK_W +: BLK_W]),
                .cout (w_c[j+1])
            );
        end

        if (s < STAGES-1) begin : g_pipe
            logic                r_v;
            logic                r_c;
            logic [WIDTH-HI-1:0] r_p;
            logic [WIDTH-HI-1:0] r_g;
            logic [HI-1:0]       r_sum;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v   <= 1'b0;
                    r_c   <= 1'b0;
                    r_p   <= '0;
                    r_g   <= '0;
                    r_sum <= '0;
                end else if (w_advance) begin
                    r_v   <= w_vin;
                    r_c   <= w_c[BPS];
                    r_p   <= w_p[WIDTH-LO-1:SW];
                    r_g   <= w_g[WIDTH-LO-1:SW];
                    r_sum <= w_s;
                end
            end
        end else begin : g_last
            logic w_ovf;

            // Carry into the MSB is recovered as p^sum at that bit.
            assign w_ovf = w_p[WIDTH-LO-1] ^ w_s[WIDTH-1] ^ w_c[BPS];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out_valid <= 1'b0;
                    r_sum       <= '0;
                    r_cout      <= 1'b0;
                    r_ovf       <= 1'b0;
                end else if (w_advance) begin
                    r_out_valid <= w_vin;
                    r_sum       <= w_s;
                    r_cout      <= w_c[BPS];
                    r_ovf       <= w_ovf;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ling_adder_pipe.sv
// ============================================================================
// Module  : tb_ling_adder_pipe
// Brief   : Three adder configurations driven in lockstep against a queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ling_adder_pipe;

    localparam int ND = 3;
    localparam int C_W  [ND] = '{16, 32, 8};
    localparam int C_ST [ND] = '{2, 4, 1};

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          t;
        bit          ns;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] v_a = '0;
    logic [31:0] v_b = '0;
    logic        v_cin = 1'b0;
    logic        v_sub = 1'b0;
    logic        v_valid = 1'b0;
    logic        v_ordy = 1'b1;
    bit          r_ns = 1'b1;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ling_adder_pipe_if #(.WIDTH(16)) bus0();
    ling_adder_pipe_if #(.WIDTH(32)) bus1();
    ling_adder_pipe_if #(.WIDTH(8))  bus2();

    assign bus0.in_valid = v_valid;  assign bus0.out_ready = v_ordy;
    assign bus0.a = v_a[15:0];       assign bus0.b = v_b[15:0];
    assign bus0.cin = v_cin;         assign bus0.sub = v_sub;
    assign bus1.in_valid = v_valid;  assign bus1.out_ready = v_ordy;
    assign bus1.a = v_a;             assign bus1.b = v_b;
    assign bus1.cin = v_cin;         assign bus1.sub = v_sub;
    assign bus2.in_valid = v_valid;  assign bus2.out_ready = v_ordy;
    assign bus2.a = v_a[7:0];        assign bus2.b = v_b[7:0];
    assign bus2.cin = v_cin;         assign bus2.sub = v_sub;

    logic [31:0] o_sum [ND];
    logic        o_ov  [ND];
    logic        o_co  [ND];
    logic        o_of  [ND];
    logic        o_rdy [ND];

    assign o_sum[0] = 32'(bus0.sum); assign o_ov[0] = bus0.out_valid;
    assign o_co[0]  = bus0.cout;     assign o_of[0] = bus0.ovf;  assign o_rdy[0] = bus0.in_ready;
    assign o_sum[1] = bus1.sum;      assign o_ov[1] = bus1.out_valid;
    assign o_co[1]  = bus1.cout;     assign o_of[1] = bus1.ovf;  assign o_rdy[1] = bus1.in_ready;
    assign o_sum[2] = 32'(bus2.sum); assign o_ov[2] = bus2.out_valid;
    assign o_co[2]  = bus2.cout;     assign o_of[2] = bus2.ovf;  assign o_rdy[2] = bus2.in_ready;

    ling_adder_pipe #(.WIDTH(16), .STAGES(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    ling_adder_pipe #(.WIDTH(32), .STAGES(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    ling_adder_pipe #(.WIDTH(8),  .STAGES(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    exp_t sbq [ND][$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: signed overflow when both addends share a
    // sign that the result does not.
    function automatic exp_t ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sub, input int t, input bit ns);
        logic [63:0] mask;
        logic [63:0] av;
        logic [63:0] bv;
        logic [63:0] full;
        exp_t        e;
        mask   = (64'd1 << w) - 64'd1;
        av     = {32'b0, a} & mask;
        bv     = sub ? (~{32'b0, b}) & mask : {32'b0, b} & mask;
        full   = av + bv + 64'(sub | cin);
        e.sum  = 32'(full & mask);
        e.cout = full[w];
        e.ovf  = (av[w-1] == bv[w-1]) && (e.sum[w-1] != av[w-1]);
        e.t    = t;
        e.ns   = ns;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            for (int d = 0; d < ND; d++) sbq[d].delete();
        end else begin
            for (int d = 0; d < ND; d++) begin
                if (o_ov[d]) begin
                    if (sbq[d].size() == 0) begin
                        chk($sformatf("d%0d_spurious", d), 64'd1, 64'd0);
                    end else begin
                        e = sbq[d][0];
                        chk($sformatf("d%0d_sum", d),  64'(o_sum[d]), 64'(e.sum));
                        chk($sformatf("d%0d_cout", d), 64'(o_co[d]),  64'(e.cout));
                        chk($sformatf("d%0d_ovf", d),  64'(o_of[d]),  64'(e.ovf));
                        if (v_ordy) begin
                            if (e.ns) chk($sformatf("d%0d_latency", d), 64'(cyc - e.t), 64'(C_ST[d]));
                            void'(sbq[d].pop_front());
                        end
                    end
                end
                if (v_valid && o_rdy[d])
                    sbq[d].push_back(ref_add(C_W[d], v_a, v_b, v_cin, v_sub, cyc, r_ns));
            end
        end
    end

    task automatic beat(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic valid);
        @(posedge clk);
        #1;
        v_a = a; v_b = b; v_cin = cin; v_sub = sub; v_valid = valid;
    endtask

    task automatic rnd_beat();
        beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    endtask

    task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            input logic sub, input logic [15:0] es, input logic ec, input logic eo);
        int n;
        beat({16'h0, a}, {16'h0, b}, cin, sub, 1'b1);
        beat('0, '0, 1'b0, 1'b0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!bus0.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("dir_valid", 64'(bus0.out_valid), 64'd1);
        chk("dir_sum",   64'(bus0.sum),       64'(es));
        chk("dir_cout",  64'(bus0.cout),      64'(ec));
        chk("dir_ovf",   64'(bus0.ovf),       64'(eo));
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("d%0d_rst_ovalid", d), 64'(o_ov[d]),  64'd0);
            chk($sformatf("d%0d_rst_irdy", d),   64'(o_rdy[d]), 64'd1);
            chk($sformatf("d%0d_rst_sum", d),    64'(o_sum[d]), 64'd0);
            chk($sformatf("d%0d_rst_cout", d),   64'(o_co[d]),  64'd0);
            chk($sformatf("d%0d_rst_ovf", d),    64'(o_of[d]),  64'd0);
        end
        rst = 1'b0;

        directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // Back-to-back stream at full throughput.
        repeat (8) begin
            rnd_beat();
            #1;
            for (int d = 0; d < ND; d++)
                chk($sformatf("d%0d_stream_irdy", d), 64'(o_rdy[d]), 64'd1);
        end
        beat('0, '0, 1'b0, 1'b0, 1'b0);
        repeat (8) @(posedge clk);

        // Fill every pipeline, then hold the output back.
        @(posedge clk);
        #1;
        r_ns   = 1'b0;
        v_ordy = 1'b0;
        repeat (6) rnd_beat();
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("d%0d_stall_irdy", d),   64'(o_rdy[d]), 64'd0);
                chk($sformatf("d%0d_stall_ovalid", d), 64'(o_ov[d]),  64'd1);
            end
        end
        @(posedge clk);
        #1;
        v_valid = 1'b0;
        v_ordy  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        r_ns = 1'b1;
        for (int d = 0; d < ND; d++)
            chk($sformatf("d%0d_drain_left", d), 64'(sbq[d].size()), 64'd0);

        // Asynchronous reset with beats in flight.
        rnd_beat();
        rnd_beat();
        @(posedge clk);
        #1 v_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("d%0d_arst_ovalid", d), 64'(o_ov[d]),  64'd0);
            chk($sformatf("d%0d_arst_sum", d),    64'(o_sum[d]), 64'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        rnd_beat();
        beat('0, '0, 1'b0, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++)
            chk($sformatf("d%0d_final_left", d), 64'(sbq[d].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
